anubis_sbox_sequencer: RTL and testbench



---
 rtl/anubis_sbox_sequencer.sv | 136 +++++++++++++
 tb/tb_anubis_sbox_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/anubis_sbox_sequencer.sv
// Anubis S-box sequencer: shares one external 8-bit S-box between two requesters.
// Each accepted NBYTES-wide word is substituted one byte per cycle, LSB byte first.
// The result is returned as a one-cycle pulse on the owning requester's result port.
// Optional macro ANUBIS_SEQ_FIXED_PRIO_EN makes req0 win every tie.
// Without it, arbitration is round-robin.
module anubis_sbox_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_data,
  output logic                res0_valid,
  output logic [8*NBYTES-1:0] res0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_data,
  output logic                res1_valid,
  output logic [8*NBYTES-1:0] res1_data,
  output logic [7:0]          sbox_idat,
  input  logic [7:0]          sbox_odat,
  output logic                busy
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_owner;
  logic [W-1:0]       r_work;
  logic [W-1:0]       r_result;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_hs;
  logic               w_last_byte;
  logic [7:0]         w_byte;
  logic [W-1:0]       w_result_next;

`ifdef ANUBIS_SEQ_FIXED_PRIO_EN
  // req0 always wins a tie
  assign w_grant1 = req1_valid & ~req0_valid;
`else
  logic               r_last_grant;
  // On a tie, grant the requester that was not served last
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
`endif
  assign w_grant0 = req0_valid & ~w_grant1;

  // Ready is only offered while idle; it is forced low during reset
  assign req0_ready = (r_state == S_IDLE) & ~rst & w_grant0;
  assign req1_ready = (r_state == S_IDLE) & ~rst & w_grant1;
  assign w_hs       = req0_ready | req1_ready;

  assign busy        = (r_state != S_IDLE);
  assign w_last_byte = (r_idx == IDX_W'(NBYTES - 1));

  // Pick the current work byte and merge the S-box output into the result image
  always_comb begin
    w_byte        = 8'h00;
    w_result_next = r_result;
    for (int b = 0; b < NBYTES; b++) begin
      if (r_idx == IDX_W'(b)) begin
        w_byte                  = r_work[8*b +: 8];
        w_result_next[8*b +: 8] = sbox_odat;
      end
    end
  end

  assign sbox_idat = (r_state == S_SUB) ? w_byte : 8'h00;

  // Control FSM with registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_owner    <= 1'b0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res0_data  <= '0;
      res1_data  <= '0;
`ifndef ANUBIS_SEQ_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_owner <= w_grant1;
            r_idx   <= '0;
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          if (w_last_byte) begin
            r_idx   <= '0;
            r_state <= S_DONE;
            if (r_owner) begin
              res1_valid <= 1'b1;
              res1_data  <= w_result_next;
            end else begin
              res0_valid <= 1'b1;
              res0_data  <= w_result_next;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
`ifndef ANUBIS_SEQ_FIXED_PRIO_EN
          r_last_grant <= r_owner;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Work word capture and per-byte result accumulation
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_work <= w_grant1 ? req1_data : req0_data;
    end
    if (r_state == S_SUB) begin
      r_result <= w_result_next;
    end
  end

endmodule

// File: tb/tb_anubis_sbox_sequencer.sv
// Directed bench for anubis_sbox_sequencer.
// Instances: u4 with NBYTES=4, and u1 with NBYTES=1.
// Each instance is wired to a behavioural Anubis S-box.
module tb_anubis_sbox_sequencer;

  logic        clk;
  logic        rst;

  logic        req0_valid, req0_ready, res0_valid;
  logic [31:0] req0_data, res0_data;
  logic        req1_valid, req1_ready, res1_valid;
  logic [31:0] req1_data, res1_data;
  logic [7:0]  sbox_idat, sbox_odat;
  logic        busy;

  logic        n0_valid, n0_ready, n_res0_valid;
  logic [7:0]  n0_data, n_res0_data;
  logic        n1_valid, n1_ready, n_res1_valid;
  logic [7:0]  n1_data, n_res1_data;
  logic [7:0]  n_sbox_idat, n_sbox_odat;
  logic        n_busy;

  int total = 0;
  int bad   = 0;

  function automatic logic [3:0] pbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'h3;  4'h1: return 4'hf;  4'h2: return 4'he;  4'h3: return 4'h0;
      4'h4: return 4'h5;  4'h5: return 4'h4;  4'h6: return 4'hb;  4'h7: return 4'hc;
      4'h8: return 4'hd;  4'h9: return 4'ha;  4'ha: return 4'h9;  4'hb: return 4'h6;
      4'hc: return 4'h7;  4'hd: return 4'h8;  4'he: return 4'h2;  default: return 4'h1;
    endcase
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    return {pbox(x[7:4]), pbox(x[3:0])};
  endfunction

  assign sbox_odat   = sbox_f(sbox_idat);
  assign n_sbox_odat = sbox_f(n_sbox_idat);

  anubis_sbox_sequencer #(.NBYTES(4)) u4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .res0_valid(res0_valid), .res0_data(res0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .res1_valid(res1_valid), .res1_data(res1_data),
    .sbox_idat(sbox_idat), .sbox_odat(sbox_odat), .busy(busy)
  );

  anubis_sbox_sequencer #(.NBYTES(1)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(n0_valid), .req0_ready(n0_ready), .req0_data(n0_data),
    .res0_valid(n_res0_valid), .res0_data(n_res0_data),
    .req1_valid(n1_valid), .req1_ready(n1_ready), .req1_data(n1_data),
    .res1_valid(n_res1_valid), .res1_data(n_res1_data),
    .sbox_idat(n_sbox_idat), .sbox_odat(n_sbox_odat), .busy(n_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] exp_seq [4];
  logic       exp_owner;

  initial begin
    exp_seq = '{8'h03, 8'h02, 8'h01, 8'h00};
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req1_valid = 1'b0; req1_data = '0;
    n0_valid = 1'b0; n0_data = '0; n1_valid = 1'b0; n1_data = '0;

    // Reset state
    repeat (2) cyc();
    req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_res0_valid", res0_valid, 1'b0);
    chk("rst_res1_valid", res1_valid, 1'b0);
    chk("rst_res0_data", res0_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sbox_idat", sbox_idat, 8'h00);
    req0_valid = 1'b0;

    // Single req0 word
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h00010203;
    #1;
    chk("t1_req0_ready", req0_ready, 1'b1);
    chk("t1_req1_ready", req1_ready, 1'b0);
    chk("t1_busy_idle", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      req0_valid = 1'b0;
      #1;
      chk("t1_sbox_idat", sbox_idat, exp_seq[i]);
      chk("t1_busy_sub", busy, 1'b1);
      chk("t1_res0_valid_early", res0_valid, 1'b0);
    end
    cyc(); #1;
    chk("t1_res0_valid", res0_valid, 1'b1);
    chk("t1_res0_data", res0_data, 32'h333f3e30);
    chk("t1_res1_valid", res1_valid, 1'b0);
    cyc(); #1;
    chk("t1_res0_pulse_end", res0_valid, 1'b0);
    chk("t1_res0_hold", res0_data, 32'h333f3e30);
    chk("t1_busy_back", busy, 1'b0);

    // Tie from reset: req0 first, then req1
    rst = 1'b1; #1; rst = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0f0f0f0f;
    req1_valid = 1'b1; req1_data = 32'hffffffff;
    #1;
    chk("t2_req0_ready", req0_ready, 1'b1);
    chk("t2_req1_ready", req1_ready, 1'b0);
    repeat (4) begin
      cyc();
      req0_valid = 1'b0;
      #1;
      chk("t2_req1_wait", req1_ready, 1'b0);
    end
    cyc(); #1;
    chk("t2_res0_valid", res0_valid, 1'b1);
    chk("t2_res0_data", res0_data, 32'h31313131);
    chk("t2_req1_ready_done", req1_ready, 1'b0);
    cyc(); #1;
    chk("t2_req1_ready_idle", req1_ready, 1'b1);
    cyc();
    req1_valid = 1'b0;
    repeat (3) cyc();
    cyc(); #1;
    chk("t2_res1_valid", res1_valid, 1'b1);
    chk("t2_res1_data", res1_data, 32'h11111111);
    chk("t2_res0_quiet", res0_valid, 1'b0);
    cyc();

    // Both continuously valid for six words
    req0_valid = 1'b1; req0_data = 32'h00010203;
    req1_valid = 1'b1; req1_data = 32'hffffffff;
    for (int k = 0; k < 6; k++) begin
`ifdef ANUBIS_SEQ_FIXED_PRIO_EN
      exp_owner = 1'b0;
`else
      exp_owner = k[0];
`endif
      #1;
      chk("t3_req0_grant", req0_ready, !exp_owner);
      chk("t3_req1_grant", req1_ready, exp_owner);
      repeat (5) cyc();
      #1;
      if (exp_owner) begin
        chk("t3_res1_valid", res1_valid, 1'b1);
        chk("t3_res1_data", res1_data, 32'h11111111);
      end else begin
        chk("t3_res0_valid", res0_valid, 1'b1);
        chk("t3_res0_data", res0_data, 32'h333f3e30);
      end
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset during the second SUB cycle
    req0_valid = 1'b1; req0_data = 32'h00010203;
    cyc();
    req0_valid = 1'b0;
    cyc(); #1;
    chk("t4_sbox_sub2", sbox_idat, 8'h02);
    rst = 1'b1;
    #1;
    chk("t4_busy", busy, 1'b0);
    chk("t4_sbox_idat", sbox_idat, 8'h00);
    chk("t4_res0_valid", res0_valid, 1'b0);
    chk("t4_res1_valid", res1_valid, 1'b0);
    chk("t4_res0_data", res0_data, 32'h0);
    chk("t4_res1_data", res1_data, 32'h0);
    chk("t4_req0_ready", req0_ready, 1'b0);
    cyc();
    rst = 1'b0;
    repeat (6) begin
      cyc(); #1;
      chk("t4_no_res0", res0_valid, 1'b0);
      chk("t4_idle", busy, 1'b0);
    end
    req1_valid = 1'b1; req1_data = 32'h00010203;
    #1;
    chk("t4_req1_ready", req1_ready, 1'b1);
    cyc();
    req1_valid = 1'b0;
    repeat (4) cyc();
    #1;
    chk("t4_res1_valid", res1_valid, 1'b1);
    chk("t4_res1_data", res1_data, 32'h333f3e30);
    chk("t4_res0_quiet", res0_valid, 1'b0);
    cyc();

    // req1 arrives while a req0 job is in flight
    req0_valid = 1'b1; req0_data = 32'h00010203;
    #1;
    chk("t5_req0_ready", req0_ready, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 32'h0f0f0f0f;
      end
      #1;
      chk("t5_req1_blocked", req1_ready, 1'b0);
      chk("t5_busy", busy, 1'b1);
      if (i == 5) chk("t5_res0_valid", res0_valid, 1'b1);
    end
    cyc(); #1;
    chk("t5_busy_idle", busy, 1'b0);
    chk("t5_req1_ready", req1_ready, 1'b1);
    cyc();
    req1_valid = 1'b0;
    repeat (3) cyc();
    cyc(); #1;
    chk("t5_res1_valid", res1_valid, 1'b1);
    chk("t5_res1_data", res1_data, 32'h31313131);
    cyc();

    // NBYTES=1 instance
    n0_valid = 1'b1; n0_data = 8'h5a;
    #1;
    chk("t6_ready", n0_ready, 1'b1);
    cyc();
    n0_valid = 1'b0;
    #1;
    chk("t6_sbox_idat", n_sbox_idat, 8'h5a);
    chk("t6_busy", n_busy, 1'b1);
    chk("t6_res_early", n_res0_valid, 1'b0);
    cyc(); #1;
    chk("t6_res0_valid", n_res0_valid, 1'b1);
    chk("t6_res0_data", n_res0_data, 8'h49);
    chk("t6_res1_valid", n_res1_valid, 1'b0);
    cyc(); #1;
    chk("t6_pulse_end", n_res0_valid, 1'b0);
    chk("t6_res1_data", n_res1_data, 8'h00);
    chk("t6_req1_ready", n1_ready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
